// File: rtl/cla_pipe_addsub.sv
// Pipelined carry-lookahead adder/subtractor.
// One 4-bit lookahead group per pipeline stage; the group carry ripples
// stage to stage through a register, the unconsumed upper operand bits
// travel down the pipe with their transaction, and the sum bits already
// produced accumulate in per-stage skew registers.  All stages advance
// together when the output slot is empty or being drained.
module cla_pipe_addsub #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             ci,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] s,
    output logic             co,
    output logic             ovf
);

    localparam int NGRP = WIDTH / 4;

    logic adv;

    for (genvar k = 0; k < NGRP; k++) begin : g_stage
        localparam int LO = 4 * k;

        logic            v_in;
        logic            sub_in;
        logic            c_in;
        logic [3:0]      ga;
        logic [3:0]      gb_raw;
        logic [3:0]      gb;
        logic [3:0]      g;
        logic [3:0]      p;
        logic [4:0]      c;
        logic [3:0]      sum;
        logic [LO+3:0]   s_prev;
        logic [LO+3:0]   s_nxt;

        logic            v_q;
        logic            c_q;
        logic [LO+3:0]   s_q;

        if (k == 0) begin : g_src
            // Stage 0 takes its operands straight from the ports; subtract
            // inverts the carry-in so that cin = !borrow_in.
            always_comb begin
                v_in   = in_valid;
                sub_in = sub;
                c_in   = sub ^ ci;
                ga     = a[3:0];
                gb_raw = b[3:0];
                s_prev = '0;
            end
        end else begin : g_src
            // Later stages consume the bottom nibble of what the previous
            // stage forwarded, plus its registered group carry.
            always_comb begin
                v_in   = g_stage[k-1].v_q;
                sub_in = g_stage[k-1].g_fwd.sub_q;
                c_in   = g_stage[k-1].c_q;
                ga     = g_stage[k-1].g_fwd.a_rem[3:0];
                gb_raw = g_stage[k-1].g_fwd.b_rem[3:0];
                s_prev = {4'b0000, g_stage[k-1].s_q};
            end
        end

        // 4-bit carry-lookahead group: all internal carries from g, p and c_in.
        always_comb begin
            gb   = gb_raw ^ {4{sub_in}};
            g    = ga & gb;
            p    = ga ^ gb;
            c[0] = c_in;
            c[1] = g[0] | (p[0] & c[0]);
            c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c[0]);
            c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
                 | (p[2] & p[1] & p[0] & c[0]);
            c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
                 | (p[3] & p[2] & p[1] & g[0]) | (&p & c[0]);
            sum  = p ^ c[3:0];
            s_nxt = s_prev;
            s_nxt[LO+3:LO] = sum;
        end

        // Stage register: valid always follows the pipe, payload only loads
        // for a real transaction so bubbles never disturb held data.
        always_ff @(posedge clk) begin
            if (!reset_n) begin
                v_q <= 1'b0;
                c_q <= 1'b0;
                s_q <= '0;
            end else if (adv) begin
                v_q <= v_in;
                if (v_in) begin
                    c_q <= c[4];
                    s_q <= s_nxt;
                end
            end
        end

        if (k < NGRP - 1) begin : g_fwd
            localparam int REM = WIDTH - LO - 4;

            logic [REM-1:0] a_up;
            logic [REM-1:0] b_up;
            logic [REM-1:0] a_rem;
            logic [REM-1:0] b_rem;
            logic           sub_q;

            if (k == 0) begin : g_up
                // Upper operand bits still to be summed, from the ports.
                always_comb begin
                    a_up = a[WIDTH-1:4];
                    b_up = b[WIDTH-1:4];
                end
            end else begin : g_up
                // Upper operand bits still to be summed, from the previous stage.
                always_comb begin
                    a_up = g_stage[k-1].g_fwd.a_rem[REM+3:4];
                    b_up = g_stage[k-1].g_fwd.b_rem[REM+3:4];
                end
            end

            // Operand skew registers carrying the unconsumed bits and the op.
            always_ff @(posedge clk) begin
                if (!reset_n) begin
                    a_rem <= '0;
                    b_rem <= '0;
                    sub_q <= 1'b0;
                end else if (adv && v_in) begin
                    a_rem <= a_up;
                    b_rem <= b_up;
                    sub_q <= sub_in;
                end
            end
        end

        if (k == NGRP - 1) begin : g_last
            logic ovf_q;

            // Signed overflow uses the MSB group only: same operand signs,
            // different result sign.
            always_ff @(posedge clk) begin
                if (!reset_n) begin
                    ovf_q <= 1'b0;
                end else if (adv && v_in) begin
                    ovf_q <= (ga[3] == gb[3]) && (sum[3] != ga[3]);
                end
            end
        end
    end

    // Output view of the last stage and the global advance/ready term.
    always_comb begin
        out_valid = g_stage[NGRP-1].v_q;
        s         = g_stage[NGRP-1].s_q;
        co        = g_stage[NGRP-1].c_q;
        ovf       = g_stage[NGRP-1].g_last.ovf_q;
        adv       = !out_valid || out_ready;
        in_ready  = adv;
    end

endmodule

// File: tb/tb_cla_pipe_addsub.sv
// Bench for cla_pipe_addsub at WIDTH=4, 16 and 32.
module tb_cla_pipe_addsub;

    typedef struct {
        int unsigned w;
        logic [31:0] a;
        logic [31:0] b;
        logic        ci;
        logic        sub;
        logic [31:0] s;
        logic        co;
        logic        ovf;
    } vec_t;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        out_ready;
    logic [31:0] a_d;
    logic [31:0] b_d;
    logic        ci_d;
    logic        sub_d;
    logic        iv    [3];
    logic        ir    [3];
    logic        ov    [3];
    logic        co_o  [3];
    logic        ovf_o [3];
    logic [3:0]  s4;
    logic [15:0] s16;
    logic [31:0] s32;
    logic [31:0] so    [3];

    int checks   = 0;
    int failures = 0;

    logic [33:0] q [3][$];
    logic        held [3];
    logic [33:0] hv   [3];
    logic        done;
    logic        acc;
    vec_t        tbl [21];

    always #5 clk = ~clk;

    always_comb begin
        so[0] = {28'd0, s4};
        so[1] = {16'd0, s16};
        so[2] = s32;
    end

    cla_pipe_addsub #(.WIDTH(4)) dut4 (
        .clk(clk), .reset_n(reset_n), .in_valid(iv[0]), .in_ready(ir[0]),
        .a(a_d[3:0]), .b(b_d[3:0]), .ci(ci_d), .sub(sub_d),
        .out_valid(ov[0]), .out_ready(out_ready), .s(s4), .co(co_o[0]), .ovf(ovf_o[0])
    );

    cla_pipe_addsub #(.WIDTH(16)) dut (
        .clk(clk), .reset_n(reset_n), .in_valid(iv[1]), .in_ready(ir[1]),
        .a(a_d[15:0]), .b(b_d[15:0]), .ci(ci_d), .sub(sub_d),
        .out_valid(ov[1]), .out_ready(out_ready), .s(s16), .co(co_o[1]), .ovf(ovf_o[1])
    );

    cla_pipe_addsub #(.WIDTH(32)) dut32 (
        .clk(clk), .reset_n(reset_n), .in_valid(iv[2]), .in_ready(ir[2]),
        .a(a_d), .b(b_d), .ci(ci_d), .sub(sub_d),
        .out_valid(ov[2]), .out_ready(out_ready), .s(s32), .co(co_o[2]), .ovf(ovf_o[2])
    );

    function automatic int unsigned wof(int i);
        return (i == 0) ? 4 : (i == 1) ? 16 : 32;
    endfunction

    // Reference: plain wide integer add; returns {ovf, co, s[31:0]}.
    function automatic logic [33:0] ref_model(int unsigned w, logic [31:0] ra,
                                              logic [31:0] rb, logic rci, logic rsub);
        logic [63:0] mask;
        logic [63:0] ea;
        logic [63:0] eb;
        logic [63:0] full;
        logic [63:0] r;
        logic        cin;
        logic        rco;
        logic        rov;
        mask = (64'd1 << w) - 64'd1;
        ea   = {32'd0, ra} & mask;
        eb   = {32'd0, (rsub ? ~rb : rb)} & mask;
        cin  = rsub ? ~rci : rci;
        full = ea + eb + {63'd0, cin};
        r    = full & mask;
        rco  = full[w];
        rov  = (ea[w-1] == eb[w-1]) && (r[w-1] != ea[w-1]);
        return {rov, rco, r[31:0]};
    endfunction

    task automatic chk(string name, logic [33:0] act, logic [33:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Scoreboard: push on accepted input, pop/compare on consumed output,
    // and verify outputs are frozen across stalled cycles.
    always @(negedge clk) begin
        logic [33:0] e;
        for (int i = 0; i < 3; i++) begin
            if (!reset_n) begin
                q[i].delete();
                held[i] = 1'b0;
            end else begin
                if (held[i]) begin
                    chk($sformatf("hold_valid_w%0d", wof(i)), {33'd0, ov[i]}, 34'd1);
                    chk($sformatf("hold_result_w%0d", wof(i)), {ovf_o[i], co_o[i], so[i]}, hv[i]);
                end
                if (ov[i] && out_ready) begin
                    if (q[i].size() == 0) begin
                        checks++;
                        failures++;
                        $display("FAIL sb_unexpected_w%0d actual=%0h required=none",
                                 wof(i), {ovf_o[i], co_o[i], so[i]});
                    end else begin
                        e = q[i].pop_front();
                        chk($sformatf("sb_result_w%0d", wof(i)), {ovf_o[i], co_o[i], so[i]}, e);
                    end
                end
                if (iv[i] && ir[i])
                    q[i].push_back(ref_model(wof(i), a_d, b_d, ci_d, sub_d));
                held[i] = ov[i] && !out_ready;
                hv[i]   = {ovf_o[i], co_o[i], so[i]};
            end
        end
    end

    // One directed op on the DUT of width v.w; result must appear exactly
    // WIDTH/4 edges after the accepting edge.
    task automatic apply_vec(input vec_t v);
        int          i;
        int unsigned lat;
        i   = (v.w == 4) ? 0 : (v.w == 16) ? 1 : 2;
        lat = v.w / 4;
        a_d = v.a; b_d = v.b; ci_d = v.ci; sub_d = v.sub;
        iv[i] = 1'b1;
        @(posedge clk); #1;
        iv[i] = 1'b0;
        if (lat > 1) begin
            repeat (lat - 2) begin @(posedge clk); #1; end
            chk($sformatf("early_valid_w%0d", v.w), {33'd0, ov[i]}, 34'd0);
            @(posedge clk); #1;
        end
        chk($sformatf("lat_valid_w%0d", v.w), {33'd0, ov[i]}, 34'd1);
        chk($sformatf("vec_s_w%0d_a%0h_b%0h", v.w, v.a, v.b), {2'b00, so[i]}, {2'b00, v.s});
        chk($sformatf("vec_co_w%0d_a%0h_b%0h", v.w, v.a, v.b), {33'd0, co_o[i]}, {33'd0, v.co});
        chk($sformatf("vec_ovf_w%0d_a%0h_b%0h", v.w, v.a, v.b), {33'd0, ovf_o[i]}, {33'd0, v.ovf});
        @(posedge clk); #1;
    endtask

    task automatic rand_ops();
        a_d   = $urandom;
        b_d   = $urandom;
        ci_d  = 1'($urandom_range(0, 1));
        sub_d = 1'($urandom_range(0, 1));
    endtask

    initial begin
        //               w   a             b             ci    sub   s             co    ovf
        tbl[0]  = '{16, 32'h0000FFFF, 32'h00000001, 1'b0, 1'b0, 32'h00000000, 1'b1, 1'b0};
        tbl[1]  = '{16, 32'h00007FFF, 32'h00000001, 1'b0, 1'b0, 32'h00008000, 1'b0, 1'b1};
        tbl[2]  = '{16, 32'h00000005, 32'h00000007, 1'b0, 1'b1, 32'h0000FFFE, 1'b0, 1'b0};
        tbl[3]  = '{16, 32'h00000010, 32'h00000001, 1'b1, 1'b1, 32'h0000000E, 1'b1, 1'b0};
        tbl[4]  = '{16, 32'h00008000, 32'h00000001, 1'b0, 1'b1, 32'h00007FFF, 1'b1, 1'b1};
        tbl[5]  = '{16, 32'h00001234, 32'h00004321, 1'b1, 1'b0, 32'h00005556, 1'b0, 1'b0};
        tbl[6]  = '{16, 32'h00000000, 32'h00000000, 1'b0, 1'b1, 32'h00000000, 1'b1, 1'b0};
        tbl[7]  = '{16, 32'h00008000, 32'h00008000, 1'b0, 1'b0, 32'h00000000, 1'b1, 1'b1};
        tbl[8]  = '{16, 32'h0000ABCD, 32'h00001111, 1'b0, 1'b0, 32'h0000BCDE, 1'b0, 1'b0};
        tbl[9]  = '{16, 32'h00000F0F, 32'h000000F1, 1'b0, 1'b0, 32'h00001000, 1'b0, 1'b0};
        tbl[10] = '{16, 32'h00000005, 32'h00000005, 1'b1, 1'b1, 32'h0000FFFF, 1'b0, 1'b0};
        tbl[11] = '{4,  32'h0000000F, 32'h00000001, 1'b0, 1'b0, 32'h00000000, 1'b1, 1'b0};
        tbl[12] = '{4,  32'h00000007, 32'h00000001, 1'b0, 1'b0, 32'h00000008, 1'b0, 1'b1};
        tbl[13] = '{4,  32'h00000005, 32'h00000007, 1'b0, 1'b1, 32'h0000000E, 1'b0, 1'b0};
        tbl[14] = '{4,  32'h00000008, 32'h00000001, 1'b0, 1'b1, 32'h00000007, 1'b1, 1'b1};
        tbl[15] = '{32, 32'hFFFFFFFF, 32'h00000001, 1'b0, 1'b0, 32'h00000000, 1'b1, 1'b0};
        tbl[16] = '{32, 32'h7FFFFFFF, 32'h00000001, 1'b0, 1'b0, 32'h80000000, 1'b0, 1'b1};
        tbl[17] = '{32, 32'h00000005, 32'h00000007, 1'b0, 1'b1, 32'hFFFFFFFE, 1'b0, 1'b0};
        tbl[18] = '{32, 32'h80000000, 32'h00000001, 1'b0, 1'b1, 32'h7FFFFFFF, 1'b1, 1'b1};
        tbl[19] = '{32, 32'h0000FFFF, 32'h00000001, 1'b0, 1'b0, 32'h00010000, 1'b0, 1'b0};
        tbl[20] = '{32, 32'h00000010, 32'h00000001, 1'b1, 1'b1, 32'h0000000E, 1'b1, 1'b0};

        // Reset held two cycles with valid inputs present.
        reset_n = 1'b0; out_ready = 1'b1; done = 1'b0;
        a_d = 32'h1; b_d = 32'h2; ci_d = 1'b0; sub_d = 1'b0;
        for (int i = 0; i < 3; i++) begin iv[i] = 1'b1; held[i] = 1'b0; end
        repeat (2) begin @(posedge clk); #1; end
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("reset_valid_w%0d", wof(i)), {33'd0, ov[i]}, 34'd0);
            chk($sformatf("reset_s_w%0d", wof(i)), {2'b00, so[i]}, 34'd0);
            chk($sformatf("reset_co_w%0d", wof(i)), {33'd0, co_o[i]}, 34'd0);
            chk($sformatf("reset_ovf_w%0d", wof(i)), {33'd0, ovf_o[i]}, 34'd0);
        end
        for (int i = 0; i < 3; i++) iv[i] = 1'b0;
        reset_n = 1'b1;

        // Directed table at all three widths.
        for (int n = 0; n < 21; n++) apply_vec(tbl[n]);

        // Back-to-back stream of 8: valid exactly on edges 3..10.
        for (int c = 0; c < 12; c++) begin
            if (c < 8) begin iv[1] = 1'b1; rand_ops(); end
            else iv[1] = 1'b0;
            @(posedge clk); #1;
            chk($sformatf("stream_valid_c%0d", c), {33'd0, ov[1]}, {33'd0, (c >= 3 && c <= 10)});
        end

        // Backpressure: three stalled cycles with a new op waiting.
        for (int c = 0; c < 4; c++) begin
            iv[1] = 1'b1; rand_ops();
            @(posedge clk); #1;
        end
        rand_ops();
        out_ready = 1'b0;
        #1;
        for (int c = 0; c < 3; c++) begin
            chk("bp_in_ready", {33'd0, ir[1]}, 34'd0);
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        iv[1] = 1'b0;
        repeat (8) begin @(posedge clk); #1; end
        chk("bp_drain", 34'(q[1].size()), 34'd0);

        // Reset with three ops in flight: nothing may emerge.
        for (int c = 0; c < 3; c++) begin
            iv[1] = 1'b1; rand_ops();
            @(posedge clk); #1;
        end
        reset_n = 1'b0; iv[1] = 1'b0;
        @(posedge clk); #1;
        reset_n = 1'b1;
        for (int c = 0; c < 6; c++) begin
            chk("rst_flush_valid", {33'd0, ov[1]}, 34'd0);
            @(posedge clk); #1;
        end
        apply_vec(tbl[1]);

        // Random valid/ready traffic, 1000 ops.
        fork
            begin
                for (int n = 0; n < 1000; n++) begin
                    while ($urandom_range(0, 3) == 0) begin
                        iv[1] = 1'b0; rand_ops();
                        @(posedge clk); #1;
                    end
                    iv[1] = 1'b1; rand_ops();
                    acc = 1'b0;
                    for (int t = 0; t < 100 && !acc; t++) begin
                        @(negedge clk);
                        acc = ir[1];
                        @(posedge clk); #1;
                    end
                    if (!acc) begin
                        checks++;
                        failures++;
                        $display("FAIL rand_accept_timeout actual=0 required=1");
                    end
                end
                iv[1] = 1'b0;
                done = 1'b1;
            end
            begin
                while (!done) begin
                    out_ready = 1'($urandom_range(0, 1));
                    @(posedge clk); #1;
                end
                out_ready = 1'b1;
            end
        join
        for (int t = 0; t < 200 && q[1].size() != 0; t++) begin @(posedge clk); #1; end
        repeat (2) begin @(posedge clk); #1; end
        for (int i = 0; i < 3; i++)
            chk($sformatf("final_drain_w%0d", wof(i)), 34'(q[i].size()), 34'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #1000000;
        failures++;
        $display("FAIL watchdog actual=timeout required=finish");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/cla_pipe_addsub.md
Name: cla_pipe_addsub

Overview:
- Parametrised, pipelined carry-lookahead adder/subtractor, WIDTH bits wide.
- Built from 4-bit lookahead groups, one group per pipeline stage; the carry ripples between stages through registers, and operand/sum skew registers keep each transaction aligned.
- Accepts one operation per cycle over a valid/ready handshake.
- Serves as the wide accumulate/add datapath for the multiplier and ALU blocks.

Parameters:
- WIDTH, 16, operand/result width in bits; must be a multiple of 4 and at least 4.
- NGRP, WIDTH/4, number of 4-bit groups = pipeline stages (derived, not overridable).

Ports:
- clk  input  1  clock; all state updates on rising edge.
- reset_n  input  1  synchronous active-low reset.
- in_valid  input  1  operands present this cycle.
- in_ready  output  1  block can accept operands this cycle.
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B.
- ci  input  1  carry-in (add) / borrow-in (sub).
- sub  input  1  0: a+b+ci; 1: a-b-ci.
- out_valid  output  1  result valid.
- out_ready  input  1  downstream accepts result.
- s  output  WIDTH  sum/difference.
- co  output  1  carry out of MSB of the internal addition.
- ovf  output  1  two's-complement signed overflow.

Behaviour:
- Reset: while reset_n=0 at a clock edge, all stage valid bits, out_valid, s, co and ovf clear to 0; in_ready=1 in the cycle after reset. Reset mid-operation discards every in-flight transaction; no partial result is emitted.
- Internal form: effective B = sub ? ~b : b; LSB carry-in = sub ? ~ci : ci; result = a + effB + cin, modulo 2^WIDTH.
  - co = raw carry out of the MSB (sub: co=1 means no borrow).
  - ovf = (a[W-1] == effB[W-1]) && (s[W-1] != a[W-1]).
- Pipeline advance: adv = !out_valid || out_ready. Every stage register loads only when adv=1; with adv=0 all stages hold (global stall).
- in_ready = adv (combinational). A transfer occurs when in_valid && in_ready.
- Stage k (k=0..NGRP-1) computes bits [4k+3:4k]:
  - g=a&effB, p=a^effB.
  - Lookahead carries c1..c3 and group carry-out come from g, p and the registered carry from stage k-1 (stage 0 uses cin).
  - Each stage registers its 4 sum bits, its group carry, its valid bit, and the still-unconsumed upper operand bits plus sub.
  - Lower sum bits already produced are carried forward in skew registers.
- Latency: NGRP cycles from accepted input to out_valid when there is no stall. Throughput is 1 per cycle.
- Bubbles propagate as invalid stages; they are not collapsed while stalled.
- s, co and ovf are registered at the last stage and remain stable while out_valid=1 and out_ready=0.
- Simultaneous input accept and output consume in one cycle is legal: full throughput, no lost or duplicated result.
- Values on a, b, ci and sub when in_valid=0 do not affect any output.
- WIDTH=4 degenerates to a single registered stage with latency 1.

Test Plan:
- Reset: hold reset_n=0 for 2 cycles with in_valid=1 -> out_valid=0, s=0, co=0, ovf=0; release -> first accepted op emerges exactly 4 cycles later (WIDTH=16).
- Add carry-out: a=0xFFFF, b=0x0001, ci=0, sub=0 -> s=0x0000, co=1, ovf=0. Add signed overflow: a=0x7FFF, b=0x0001 -> s=0x8000, co=0, ovf=1.
- Subtract with borrow: a=0x0005, b=0x0007, ci=0, sub=1 -> s=0xFFFE, co=0, ovf=0. Borrow-in: a=0x0010, b=0x0001, ci=1, sub=1 -> s=0x000E, co=1. Signed overflow: a=0x8000, b=0x0001, sub=1 -> s=0x7FFF, ovf=1.
- Back-to-back stream: 8 consecutive ops with out_ready=1 -> 8 results on 8 consecutive cycles, in order, each matching the reference model, first at latency 4.
- Backpressure: drop out_ready for 3 cycles while results are pending -> in_ready=0, s/co/ovf held stable, nothing lost or duplicated after out_ready returns; random in_valid/out_ready over 1000 ops checked against the model.
- Reset mid-stream: assert reset_n=0 with 3 ops in flight -> none emerge afterwards; the next op after release is correct. Repeat the directed cases at WIDTH=4 (latency 1) and WIDTH=32 (latency 8).
